// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered binary-to-one-hot decoder with N = 2^AW
// outputs, output enable, explicit address load and an optional auto-scan
// sequencer that walks the active output up or down once every DIV clocks.
//
// Build option: define ONEHOT_SCAN_EN to build the scan sequencer (FSM,
// prescaler, direction control and wrap pulse). Without it, scan and dir are
// ignored, wrap is tied low and idx changes only on load or reset.
//
// Handshake: there is no valid/ready pair. load is a one-cycle strobe that
// is consumed on the edge that samples it; scan, dir and en are levels
// sampled on every rising edge. All outputs are registered.
module onehot_scan_decoder #(
   parameter int AW  = 3,
   parameter int DIV = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [AW-1:0]       addr,
   input  logic                load,
   input  logic                scan,
   input  logic                dir,
   input  logic                en,
   output logic [(1<<AW)-1:0]  y,
   output logic [AW-1:0]       idx,
   output logic                wrap
);

   localparam int N = 1 << AW;

   logic [AW-1:0] idx_next;
   logic          wrap_next;
   logic [N-1:0]  y_next;

`ifdef ONEHOT_SCAN_EN
   localparam int            PW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

   typedef enum logic {
      HOLD = 1'b0,
      SCAN = 1'b1
   } state_t;

   // state is kept as a named signal so checkers can bind to the FSM.
   state_t        state;
   state_t        state_next;
   logic [PW-1:0] pcnt;
   logic [PW-1:0] pcnt_next;
   logic          step;

   // FSM state and prescaler registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= HOLD;
         pcnt  <= '0;
      end else begin
         state <= state_next;
         pcnt  <= pcnt_next;
      end
   end

   // Next state, prescaler, index and wrap. A load overrides any step and
   // restarts the prescaler without changing the FSM state.
   always_comb begin
      state_next = state;
      pcnt_next  = '0;
      idx_next   = idx;
      step       = 1'b0;
      wrap_next  = 1'b0;
      if (load) begin
         idx_next = addr;
      end else begin
         case (state)
            HOLD: begin
               if (scan) state_next = SCAN;
            end
            SCAN: begin
               if (!scan) begin
                  state_next = HOLD;
               end else if (pcnt == PLAST) begin
                  step = 1'b1;
               end else begin
                  pcnt_next = pcnt + PW'(1);
               end
            end
            default: state_next = HOLD;
         endcase
         // dir is only looked at here, so a mid-period change applies at
         // the next step.
         if (step) begin
            if (dir) begin
               idx_next  = idx - AW'(1);
               wrap_next = (idx == '0);
            end else begin
               idx_next  = idx + AW'(1);
               wrap_next = (idx == '1);
            end
         end
      end
   end
`else
   // scan and dir have no function in this build.
   logic unused_scan_inputs;
   assign unused_scan_inputs = ^{scan, dir};

   // Index changes only on load; wrap never fires.
   always_comb begin
      idx_next  = load ? addr : idx;
      wrap_next = 1'b0;
   end
`endif

   // Decode the index the register takes on this edge so y always matches idx.
   always_comb begin
      y_next = '0;
      if (en) y_next = N'(1) << idx_next;
   end

   // Output and index registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx  <= '0;
         y    <= '0;
         wrap <= 1'b0;
      end else begin
         idx  <= idx_next;
         y    <= y_next;
         wrap <= wrap_next;
      end
   end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: directed plus randomized bench for
// onehot_scan_decoder (AW=3, DIV=4). A behavioural model predicts
// {wrap, idx, y} for every edge into exp_q; a compare process checks the DUT
// on every falling edge. Directed steps also check hand-computed literals.
// Follows ONEHOT_SCAN_EN the same way as the design.
module tb_onehot_scan_decoder;

   localparam int AW  = 3;
   localparam int DIV = 4;
   localparam int N   = 1 << AW;
   localparam int W   = 1 + AW + N;

   logic          clk;
   logic          reset;
   logic [AW-1:0] addr;
   logic          load;
   logic          scan;
   logic          dir;
   logic          en;
   logic [N-1:0]  y;
   logic [AW-1:0] idx;
   logic          wrap;

   int n_total = 0;
   int n_pass  = 0;

   logic [W-1:0] exp_q[$];

   onehot_scan_decoder #(.AW(AW), .DIV(DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .load  (load),
      .scan  (scan),
      .dir   (dir),
      .en    (en),
      .y     (y),
      .idx   (idx),
      .wrap  (wrap)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Tracks the index as an integer, whether scanning is active, and how many
   // clocks have elapsed in the current scan period.
   int m_idx     = 0;
   bit m_scan    = 0;
   int m_elapsed = 0;

   always @(posedge clk) begin
      int m_wrap;
      int m_y;
      m_wrap = 0;
      if (reset) begin
         m_idx = 0; m_scan = 0; m_elapsed = 0;
      end else begin
`ifdef ONEHOT_SCAN_EN
         if (load) begin
            m_idx = int'(addr); m_elapsed = 0;
         end else if (!m_scan) begin
            if (scan) m_scan = 1;
            m_elapsed = 0;
         end else if (!scan) begin
            m_scan = 0; m_elapsed = 0;
         end else begin
            m_elapsed++;
            if (m_elapsed == DIV) begin
               m_elapsed = 0;
               if (dir) begin
                  m_wrap = (m_idx == 0) ? 1 : 0;
                  m_idx  = (m_idx + N - 1) % N;
               end else begin
                  m_wrap = (m_idx == N - 1) ? 1 : 0;
                  m_idx  = (m_idx + 1) % N;
               end
            end
         end
`else
         if (load) m_idx = int'(addr);
`endif
      end
      m_y = (!reset && en) ? (1 << m_idx) : 0;
      exp_q.push_back({m_wrap[0], m_idx[AW-1:0], m_y[N-1:0]});
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("model_y",    32'(y),    32'(e[N-1:0]));
         chk("model_idx",  32'(idx),  32'(e[N+AW-1:N]));
         chk("model_wrap", 32'(wrap), 32'(e[W-1]));
         chk("onehot",     32'($countones(y) <= 1), 32'd1);
      end
   end

   // ---------------- driver tasks ----------------
   // Inputs change 2 time units after a rising edge; outputs are stable then.
   task automatic cyc(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_load(input int a);
      load = 1'b1; addr = AW'(a);
      cyc();
      load = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [N-1:0] lit_y [0:7];
      logic [N-1:0] y_hold;
      logic [AW-1:0] idx_hold;
      bit wrap_seen;
      lit_y[0] = 8'h01; lit_y[1] = 8'h02; lit_y[2] = 8'h04; lit_y[3] = 8'h08;
      lit_y[4] = 8'h10; lit_y[5] = 8'h20; lit_y[6] = 8'h40; lit_y[7] = 8'h80;

      reset = 1'b1; addr = '0; load = 1'b0; scan = 1'b0; dir = 1'b0; en = 1'b1;
      cyc(3);
      chk("reset_y", 32'(y), 32'h00);
      chk("reset_wrap", 32'(wrap), 32'h0);
      reset = 1'b0;
      cyc();
      chk("release_y", 32'(y), 32'h01);
      chk("release_idx", 32'(idx), 32'h0);

      // Every code in turn, one load per clock.
      for (int i = 0; i < 8; i++) begin
         load = 1'b1; addr = AW'(i);
         cyc();
         chk("load_code_y", 32'(y), 32'(lit_y[i]));
         chk("load_code_idx", 32'(idx), i);
      end
      load = 1'b0;

`ifdef ONEHOT_SCAN_EN
      // Up scan from 6 through the wrap.
      do_load(6);
      scan = 1'b1; dir = 1'b0;
      cyc();                              // enters SCAN
      cyc(3);
      chk("up_pre_step_y", 32'(y), 32'h40);
      cyc();
      chk("up_step1_y", 32'(y), 32'h80);
      chk("up_step1_wrap", 32'(wrap), 32'h0);
      cyc(4);
      chk("up_wrap_y", 32'(y), 32'h01);
      chk("up_wrap_pulse", 32'(wrap), 32'h1);
      cyc();
      chk("up_wrap_one_clk", 32'(wrap), 32'h0);

      // Down scan from 1 through the wrap, then stop.
      scan = 1'b0;
      cyc();
      do_load(1);
      scan = 1'b1; dir = 1'b1;
      cyc();
      cyc(4);
      chk("down_step1_idx", 32'(idx), 32'h0);
      cyc(4);
      chk("down_wrap_idx", 32'(idx), 32'h7);
      chk("down_wrap_y", 32'(y), 32'h80);
      chk("down_wrap_pulse", 32'(wrap), 32'h1);
      scan = 1'b0;
      cyc(10);
      chk("down_hold_idx", 32'(idx), 32'h7);

      // Mid-period load restarts the prescaler; en gates y only.
      scan = 1'b1; dir = 1'b0;
      cyc();
      cyc(2);
      load = 1'b1; addr = 3'd3;
      cyc();
      load = 1'b0;
      chk("midload_idx", 32'(idx), 32'h3);
      cyc(3);
      chk("midload_no_early_step", 32'(idx), 32'h3);
      cyc();
      chk("midload_step_idx", 32'(idx), 32'h4);
      en = 1'b0;
      cyc();
      chk("en_off_y", 32'(y), 32'h00);
      cyc(4);
      chk("en_off_idx_counts", 32'(idx), 32'h5);
      en = 1'b1;
      cyc();
      chk("en_on_y", 32'(y), 32'h20);
      scan = 1'b0;
      cyc();
`else
      // scan/dir have no effect in this build.
      do_load(5);
      y_hold = y; idx_hold = idx; wrap_seen = 0;
      scan = 1'b1;
      for (int i = 0; i < 20; i++) begin
         dir = 1'($urandom_range(0, 1));
         cyc();
         if (wrap) wrap_seen = 1;
      end
      chk("noscan_idx", 32'(idx), 32'h5);
      chk("noscan_y", 32'(y), 32'h20);
      chk("noscan_stable", 32'({y, idx}), 32'({y_hold, idx_hold}));
      chk("noscan_wrap", 32'(wrap_seen), 32'h0);
      do_load(2);
      chk("noscan_load_y", 32'(y), 32'h04);
      scan = 1'b0;
`endif

      // Randomized traffic checked by the model.
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         load  = ($urandom_range(0, 9) == 0);
         addr  = AW'($urandom_range(0, N - 1));
         if ($urandom_range(0, 19) == 0) scan = ~scan;
         if ($urandom_range(0, 5) == 0) dir = ~dir;
         if ($urandom_range(0, 15) == 0) en = ~en;
         cyc();
      end
      reset = 1'b0; load = 1'b0;
      cyc(2);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Hard bound on simulated time.
   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Parametrised, registered binary-to-one-hot decoder with an optional auto-scan sequencer. It generalises the 3-to-8 combinational decoder to 2^AW outputs with output enable, explicit address load and an up/down scan mode that walks the active output at a programmable rate. It drives digit/row select lines for multiplexed displays and keyboard matrices.

## Interface
- AW, 3, address width; output count N = 2^AW (AW 1..6)
- DIV, 4, clocks per scan step (DIV ≥ 1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- addr  in  AW  address to load
- load  in  1  one-cycle strobe: latch addr into index
- scan  in  1  level: auto-advance index every DIV clocks
- dir  in  1  scan direction: 0 = up, 1 = down
- en  in  1  output enable: 0 forces y to all-zero
- y  out  N  registered one-hot output
- idx  out  AW  current index register
- wrap  out  1  one-cycle pulse on scan wrap-around

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- Internal state: idx (AW bits), prescaler pcnt (0..DIV-1), FSM {HOLD, SCAN}.
- Next-index priority per edge: reset > load > scan step > hold.
- load=1: idx ← addr, pcnt ← 0; FSM state unchanged; wrap=0 that cycle even if addr causes a numeric wrap.
- FSM: HOLD → SCAN when scan=1 and load=0; SCAN → HOLD when scan=0. Any load while in SCAN restarts the prescaler.
- In SCAN: pcnt increments each clock; at pcnt == DIV-1, pcnt ← 0 and idx steps (up: +1, down: −1).
- Wrap: up from N-1 → 0, or down from 0 → N-1; wrap=1 on the clock that registers the wrapped idx.
- Leaving SCAN: pcnt ← 0, idx holds last value.
- dir is sampled only on step edges; changing dir mid-period takes effect at the next step.
- Output: y ← en ? (1 << idx_next) : 0, with idx_next the value idx takes on the same edge. y is therefore always consistent with idx; never more than one bit set.
- Arithmetic is modulo 2^AW; no out-of-range index exists.

## Timing
- Reset values: idx=0, pcnt=0, FSM=HOLD, y=0, wrap=0. y stays 0 until the first edge after reset deasserts; then y=0x01 if en=1.
- load → y/idx latency: 1 clock (visible after the edge sampling load).
- en → y latency: 1 clock, both edges.
- Scan: first step occurs DIV clocks after the edge that enters SCAN; subsequent steps every DIV clocks. DIV=1 steps every clock.
- load and scan both high: load wins, prescaler restarts, the next step comes DIV clocks later.
- Reset mid-scan: all state returns to reset values on that edge; scan must be re-sampled from HOLD.
- wrap is high for exactly one clock, aligned with y showing the wrapped index.

## Configuration
- ONEHOT_SCAN_EN defined: full behaviour above (FSM, prescaler, dir, wrap).
- Not defined: scan and dir are ignored, no prescaler or FSM is built, wrap is tied 0; idx changes only on load or reset. Load, en and y timing are unchanged.

## Test plan
- Reset with en=1, then release → y=0x00 during reset, y=0x01 and idx=0 one clock later.
- AW=3, load addr=0..7 in turn, one per clock, en=1 → y = 0x01, 0x02 … 0x80, each 1 clock after its load; all eight codes covered, none missing.
- Load addr=6, DIV=4, scan=1, dir=0 → y: 0x40 → 0x80 → 0x01 at 4-clock spacing, wrap=1 only on the 0x01 edge.
- Load addr=1, scan=1, dir=1 → idx 1 → 0 → 7, wrap pulse with y=0x80; drop scan → idx holds at 7, no further steps.
- Scan running, assert load addr=3 mid-period together with scan=1 → idx=3 next clock, next step to 4 exactly DIV clocks later; toggle en=0 → y=0x00 one clock later, idx keeps counting.
- Build without ONEHOT_SCAN_EN, scan=1 for 20 clocks → idx/y constant, wrap never asserted; load still functions.
